ifu: RTL and testbench
======================

Name: ifu

Overview:
- Instruction fetch unit for the multicycle MIPS core. Holds the PC and the instruction register (IR) and computes the next PC.
- Fetches from instruction memory over a req/rdy handshake and feeds Op/Funct/imm fields to ctrl.
- Sits directly upstream of ctrl. Consumes its PCWr, IRWr, NPCOp and Zero outputs; reports fetch completion back so ctrl can stall Fetch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- AW, 32, PC / imem address width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- IRWr  in  1  fetch request pulse from ctrl (Fetch state)
- PCWr  in  1  PC update enable from ctrl
- NPCOp  in  2  next-PC select: 00 PC+4, 01 BNE, 10 J/JAL, 11 JR
- Zero  in  1  ALU zero flag, used for BNE
- RD1  in  32  rs register value, used for JR
- imem_req  out  1  instruction memory request
- imem_addr  out  AW  word-aligned fetch address
- imem_rdy  in  1  memory returns data this cycle
- imem_rdata  in  32  instruction word
- PC  out  AW  current PC
- PCPlus4  out  AW  PC+4, the JAL link value
- IR  out  32  latched instruction
- if_busy  out  1  fetch in progress; ctrl must hold Fetch while high
- ir_valid  out  1  one-cycle pulse when IR is loaded

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: PC=RESET_PC, IR=0, imem_req=0, if_busy=0, ir_valid=0, FSM=IDLE.
- FSM states:
  - IDLE: on IRWr go to REQ; if_busy rises the same cycle (combinational from IRWr).
  - REQ: imem_req=1, imem_addr=PC. If imem_rdy, latch IR<=imem_rdata, pulse ir_valid next cycle, go to IDLE. Otherwise go to WAIT.
  - WAIT: imem_req held at 1 with imem_addr stable until imem_rdy; then latch IR and go to IDLE.
- Handshake: zero-wait memory gives 1-cycle fetch latency (IRWr at cycle n, IR valid at n+1). Each wait cycle adds one.
- imem_req and imem_addr must not change while waiting.
- IRWr while busy: ignored; no second request is queued.
- Next PC, computed combinationally from the current PC and IR:
  - 00: PC+4.
  - 01: if Zero==0 (BNE taken), PC+4 + (sext(IR[15:0])<<2); else PC+4.
  - 10: {PCPlus4[31:28], IR[25:0], 2'b00}.
  - 11: RD1.
- PC update: PC<=NPC on a posedge with PCWr=1. All arithmetic is modulo 2^AW; PC+4 wraps from 32'hFFFF_FFFC to 0.
- PCWr while busy: PC update suppressed; the fetch in flight keeps its old address. ctrl must not do this.
- PCWr and IRWr in the same IDLE cycle: fetch uses the old PC and the PC updates. ctrl must not do this.
- Reset mid-fetch: abort immediately. imem_req drops asynchronously, IR is not loaded, and an imem_rdy arriving after reset is ignored.
- IR holds its value between fetches.

Optional Feature:
- Macro IFU_ALIGN_CHK_EN.
- Defined: adds output if_misalign, 1 bit, reset 0.
  - On any PC update whose NPC[1:0]!=0 (JR target), PC is still written, if_misalign sets and stays set until reset, and further IRWr is ignored. The core halts in Fetch with if_busy=0.
- Undefined: no port; NPC[1:0] is forced to 00 on JR.

Decomposition:
- ctrl_encode_def.v gains NPCOp_PLUS4/BNE/JUMP/JR (2'b00..11) and the IFU state encodings IFU_IDLE/REQ/WAIT.
- One sub-module, npc: combinational next-PC calculator (PC, IR, NPCOp, Zero, RD1 -> NPC, PCPlus4).
- ifu instantiates npc and owns the PC register, IR register and FSM.

Test Plan:
- Reset, then IRWr with imem_rdy=1 and rdata=32'h3421_0005 -> imem_addr=32'h3000, IR=32'h3421_0005 next cycle, ir_valid pulses once.
- IRWr with imem_rdy delayed 3 cycles -> imem_req/addr stable for 4 cycles, if_busy high throughout, IR loads on rdy.
- IR=BNE, imm=16'hFFFF, PC=32'h3008, Zero=0, NPCOp=01, PCWr -> PC=32'h3008; same with Zero=1 -> PC=32'h300C.
- IR=JAL, index=26'h0000C10, PC=32'h3010 -> PC=32'h0000_3040, PCPlus4=32'h3014 before the update; NPCOp=11, RD1=32'h3024 -> PC=32'h3024.
- Assert rst during WAIT -> imem_req=0 immediately, PC=RESET_PC, a late imem_rdy does not change IR.
- With IFU_ALIGN_CHK_EN: JR to 32'h3002 -> if_misalign=1, a later IRWr causes no imem_req. Without the macro -> PC=32'h3000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes
// and the fetch FSM state encoding.
package ifu_pkg;

    // Next-PC select codes driven by ctrl on NPCOp
    localparam logic [1:0] NPCOP_PLUS4 = 2'b00;
    localparam logic [1:0] NPCOP_BNE   = 2'b01;
    localparam logic [1:0] NPCOP_JUMP  = 2'b10;
    localparam logic [1:0] NPCOP_JR    = 2'b11;

    // Fetch FSM states.
    // IFU_REQ is the first cycle after a request went out without data.
    // IFU_WAIT covers every cycle after that, until imem_rdy arrives.
    typedef enum logic [1:0] {
        IFU_IDLE = 2'b00,
        IFU_REQ  = 2'b01,
        IFU_WAIT = 2'b10
    } ifu_state_t;

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC calculator for the multicycle MIPS core.
// Optional macro IFU_ALIGN_CHK_EN: when defined, JR targets pass through
// unmodified so the fetch unit can flag misalignment; otherwise the low two
// bits of a JR target are cleared.
module ifu_npc
    import ifu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] PC,
    input  logic [25:0]   IR,
    input  logic [1:0]    NPCOp,
    input  logic          Zero,
    input  logic [AW-1:0] RD1,
    output logic [AW-1:0] NPC,
    output logic [AW-1:0] PCPlus4
);

    logic [AW-1:0] w_pcPlus4;
    logic [AW-1:0] w_branchOffset;
    logic [AW-1:0] w_branchTarget;
    logic [AW-1:0] w_jumpTarget;
    logic [AW-1:0] w_jrTarget;

    // The 16-bit branch immediate is sign-extended and turned into a byte
    // offset. All sums wrap modulo 2^AW.
    assign w_pcPlus4      = PC + AW'(4);
    assign w_branchOffset = {{(AW-18){IR[15]}}, IR[15:0], 2'b00};
    assign w_branchTarget = w_pcPlus4 + w_branchOffset;
    assign w_jumpTarget   = {w_pcPlus4[AW-1:28], IR[25:0], 2'b00};

`ifdef IFU_ALIGN_CHK_EN
    assign w_jrTarget = RD1;
`else
    assign w_jrTarget = RD1 & {{(AW-2){1'b1}}, 2'b00};
`endif

    // Select the next PC. BNE is taken when the ALU reports not-equal (Zero low).
    always_comb begin
        NPC = w_pcPlus4;
        case (NPCOp)
            NPCOP_PLUS4: NPC = w_pcPlus4;
            NPCOP_BNE:   NPC = Zero ? w_pcPlus4 : w_branchTarget;
            NPCOP_JUMP:  NPC = w_jumpTarget;
            NPCOP_JR:    NPC = w_jrTarget;
            default:     NPC = w_pcPlus4;
        endcase
    end

    assign PCPlus4 = w_pcPlus4;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, the instruction register and the
// imem req/rdy fetch FSM. Next-PC logic lives in ifu_npc.
// Optional macro IFU_ALIGN_CHK_EN adds the if_misalign output. A misaligned
// PC write sets it and blocks further fetches until reset.
module ifu
    import ifu_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IRWr,
    input  logic          PCWr,
    input  logic [1:0]    NPCOp,
    input  logic          Zero,
    input  logic [31:0]   RD1,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rdy,
    input  logic [31:0]   imem_rdata,
    output logic [AW-1:0] PC,
    output logic [AW-1:0] PCPlus4,
    output logic [31:0]   IR,
    output logic          if_busy,
    output logic          ir_valid
`ifdef IFU_ALIGN_CHK_EN
    ,
    output logic          if_misalign
`endif
);

    ifu_state_t    r_state;
    ifu_state_t    w_nextState;
    logic [AW-1:0] r_pc;
    logic [31:0]   r_ir;
    logic          r_irValid;
    logic [AW-1:0] w_npc;
    logic          w_halt;
    logic          w_issue;
    logic          w_req;
    logic          w_load;
    logic          w_pcUpdate;

    ifu_npc #(
        .AW(AW)
    ) u_npc (
        .PC      (r_pc),
        .IR      (r_ir[25:0]),
        .NPCOp   (NPCOp),
        .Zero    (Zero),
        .RD1     (RD1[AW-1:0]),
        .NPC     (w_npc),
        .PCPlus4 (PCPlus4)
    );

    // A fetch issues in the same cycle IRWr arrives in IDLE. This gives a
    // zero-wait memory one-cycle latency. Gating with rst keeps imem_req low
    // for the whole time reset is asserted.
    assign w_issue    = (r_state == IFU_IDLE) && IRWr && !w_halt && !rst;
    assign w_req      = w_issue || (r_state != IFU_IDLE);
    assign w_load     = w_req && imem_rdy;
    assign w_pcUpdate = PCWr && (r_state == IFU_IDLE);

    // Fetch FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IFU_IDLE;
        else     r_state <= w_nextState;
    end

    // Fetch FSM next state. Every state returns to IDLE when data arrives.
    // IRWr outside IDLE is ignored.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IFU_IDLE: if (w_issue && !imem_rdy) w_nextState = IFU_REQ;
            IFU_REQ:  w_nextState = imem_rdy ? IFU_IDLE : IFU_WAIT;
            IFU_WAIT: if (imem_rdy) w_nextState = IFU_IDLE;
            default:  w_nextState = IFU_IDLE;
        endcase
    end

    // PC register. The PC only moves while no fetch is outstanding, so the
    // fetch address stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_pc <= RESET_PC;
        else if (w_pcUpdate) r_pc <= w_npc;
    end

    // IR capture and the one-cycle ir_valid pulse that follows it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir      <= 32'h0;
            r_irValid <= 1'b0;
        end else begin
            r_irValid <= w_load;
            if (w_load) r_ir <= imem_rdata;
        end
    end

`ifdef IFU_ALIGN_CHK_EN
    logic r_misalign;

    // Sticky misalignment flag. Once set, it halts fetching until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_misalign <= 1'b0;
        else if (w_pcUpdate && (w_npc[1:0] != 2'b00)) r_misalign <= 1'b1;
    end

    assign w_halt      = r_misalign;
    assign if_misalign = r_misalign;
`else
    assign w_halt = 1'b0;
`endif

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign if_busy   = w_req;
    assign ir_valid  = r_irValid;
    assign PC        = r_pc;
    assign IR        = r_ir;

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu. It exercises reset, zero-wait and
// delayed fetches, the next-PC modes, PC wrap, reset during a wait, and
// JR misalignment handling.
module tb_ifu;

    logic        clk;
    logic        rst;
    logic        IRWr;
    logic        PCWr;
    logic [1:0]  NPCOp;
    logic        Zero;
    logic [31:0] RD1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] IR;
    logic        if_busy;
    logic        ir_valid;
`ifdef IFU_ALIGN_CHK_EN
    logic        if_misalign;
`endif

    int total = 0;
    int bad   = 0;

    ifu dut (
        .clk        (clk),
        .rst        (rst),
        .IRWr       (IRWr),
        .PCWr       (PCWr),
        .NPCOp      (NPCOp),
        .Zero       (Zero),
        .RD1        (RD1),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_rdata (imem_rdata),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .IR         (IR),
        .if_busy    (if_busy),
        .ir_valid   (ir_valid)
`ifdef IFU_ALIGN_CHK_EN
        ,
        .if_misalign(if_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every input at once and let the combinational outputs settle
    task automatic applyStimulus(input logic irwr, input logic pcwr, input logic [1:0] npcop,
                                 input logic zero, input logic [31:0] rd1,
                                 input logic rdy, input logic [31:0] rdata);
        IRWr       = irwr;
        PCWr       = pcwr;
        NPCOp      = npcop;
        Zero       = zero;
        RD1        = rd1;
        imem_rdy   = rdy;
        imem_rdata = rdata;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One PC write with the given select
    task automatic pcStep(input logic [1:0] npcop, input logic zero, input logic [31:0] rd1);
        applyStimulus(1'b0, 1'b1, npcop, zero, rd1, 1'b0, 32'h0);
        tick();
        idle();
    endtask

    // Zero-wait fetch: the memory answers in the request cycle
    task automatic fetchNow(input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, data);
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc",       PC,       32'h0000_3000);
        checkOutput("rst_ir",       IR,       32'h0);
        checkOutput("rst_req",      imem_req, 32'h0);
        checkOutput("rst_busy",     if_busy,  32'h0);
        checkOutput("rst_irvalid",  ir_valid, 32'h0);
        rst = 1'b0;

        // Zero-wait fetch at the reset PC
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h3421_0005);
        checkOutput("f1_req",  imem_req,  32'h1);
        checkOutput("f1_addr", imem_addr, 32'h0000_3000);
        checkOutput("f1_busy", if_busy,   32'h1);
        tick();
        idle();
        checkOutput("f1_ir",      IR,       32'h3421_0005);
        checkOutput("f1_irvalid", ir_valid, 32'h1);
        checkOutput("f1_busy_lo", if_busy,  32'h0);
        checkOutput("f1_req_lo",  imem_req, 32'h0);
        tick();
        checkOutput("f1_irvalid_once", ir_valid, 32'h0);

        pcStep(2'b00, 1'b0, 32'h0);
        checkOutput("pc_plus4", PC, 32'h0000_3004);

        // Delayed fetch: memory answers in the fourth request cycle
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("d_req0",  imem_req,  32'h1);
        checkOutput("d_addr0", imem_addr, 32'h0000_3004);
        tick();
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("d_req1",  imem_req,  32'h1);
        checkOutput("d_addr1", imem_addr, 32'h0000_3004);
        checkOutput("d_busy1", if_busy,   32'h1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("d_pc_hold", PC,        32'h0000_3004);
        checkOutput("d_req2",    imem_req,  32'h1);
        checkOutput("d_addr2",   imem_addr, 32'h0000_3004);
        checkOutput("d_busy2",   if_busy,   32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'hAAAA_5555);
        checkOutput("d_req3",    imem_req,  32'h1);
        checkOutput("d_addr3",   imem_addr, 32'h0000_3004);
        checkOutput("d_ir_hold", IR,        32'h3421_0005);
        tick();
        idle();
        checkOutput("d_ir",      IR,       32'hAAAA_5555);
        checkOutput("d_irvalid", ir_valid, 32'h1);
        checkOutput("d_req_lo",  imem_req, 32'h0);
        checkOutput("d_busy_lo", if_busy,  32'h0);
        tick();
        checkOutput("d_no_queue", imem_req, 32'h0);
        checkOutput("d_irvalid_once", ir_valid, 32'h0);

        // BNE with offset -1 word at PC 0x3008
        pcStep(2'b00, 1'b0, 32'h0);
        checkOutput("pc_3008", PC, 32'h0000_3008);
        fetchNow(32'h1420_FFFF);
        checkOutput("bne_ir", IR, 32'h1420_FFFF);
        pcStep(2'b01, 1'b0, 32'h0);
        checkOutput("bne_taken", PC, 32'h0000_3008);
        pcStep(2'b01, 1'b1, 32'h0);
        checkOutput("bne_not_taken", PC, 32'h0000_300C);

        // JAL then JR
        pcStep(2'b00, 1'b0, 32'h0);
        checkOutput("pc_3010", PC, 32'h0000_3010);
        fetchNow(32'h0C00_0C10);
        checkOutput("jal_link", PCPlus4, 32'h0000_3014);
        pcStep(2'b10, 1'b0, 32'h0);
        checkOutput("jal_pc", PC, 32'h0000_3040);
        pcStep(2'b11, 1'b0, 32'h0000_3024);
        checkOutput("jr_pc", PC, 32'h0000_3024);

        // PC+4 wraps at the top of the address space
        pcStep(2'b11, 1'b0, 32'hFFFF_FFFC);
        checkOutput("wrap_pc",    PC,      32'hFFFF_FFFC);
        checkOutput("wrap_plus4", PCPlus4, 32'h0);
        pcStep(2'b00, 1'b0, 32'h0);
        checkOutput("wrap_zero", PC, 32'h0);
        pcStep(2'b11, 1'b0, 32'h0000_3020);
        checkOutput("pc_3020", PC, 32'h0000_3020);

        // Reset while waiting on memory
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        checkOutput("rw_req_before", imem_req, 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rw_req_async", imem_req, 32'h0);
        checkOutput("rw_busy",      if_busy,  32'h0);
        checkOutput("rw_pc",        PC,       32'h0000_3000);
        checkOutput("rw_ir",        IR,       32'h0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        #2 rst = 1'b0;
        tick();
        idle();
        checkOutput("rw_late_ir",      IR,       32'h0);
        checkOutput("rw_late_irvalid", ir_valid, 32'h0);
        checkOutput("rw_late_req",     imem_req, 32'h0);

        // JR to an unaligned target
        pcStep(2'b11, 1'b0, 32'h0000_3002);
`ifdef IFU_ALIGN_CHK_EN
        checkOutput("mis_pc",   PC,          32'h0000_3002);
        checkOutput("mis_flag", if_misalign, 32'h1);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        checkOutput("mis_req",  imem_req, 32'h0);
        checkOutput("mis_busy", if_busy,  32'h0);
        tick();
        idle();
        checkOutput("mis_ir",   IR,          32'h0);
        checkOutput("mis_hold", if_misalign, 32'h1);
`else
        checkOutput("jr_align_pc", PC, 32'h0000_3000);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        checkOutput("jr_align_addr", imem_addr, 32'h0000_3000);
        tick();
        idle();
        checkOutput("jr_align_ir", IR, 32'h1234_5678);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
